// File: rtl/demux_defs.sv
// Shared constants, select classification and sizing helper for the 1-to-N stream demux.
package demux_defs;

    localparam int unsigned DEMUX_MAX_N = 16;
    localparam int unsigned DROP_CNT_W  = 8;

    typedef enum logic [1:0] {
        KIND_UNICAST = 2'd0,
        KIND_BCAST   = 2'd1,
        KIND_DROP    = 2'd2
    } sel_kind_e;

    // Smallest select width able to address n channels (ceiling log2).
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with valid/ready handshake for a single demux channel.
module demux_slot
    import demux_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_free
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // A slot being drained this cycle can take a new word on the same edge.
    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        // NOTE: data is reset too, because consumers observe out_data=0 after reset.
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demux: unicast or broadcast steering, per-channel holding slots, drop counting.
module stream_demux_1ton
    import demux_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_bcast,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N*WIDTH-1:0]    out_data,
    output logic [N-1:0]          out_valid,
    input  logic [N-1:0]          out_ready,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  err
);

    generate
        if (N < 2 || N > DEMUX_MAX_N || SEL_W < sel_width(N)) begin : g_bad_params
            $error("stream_demux_1ton: N must be 2..16 and SEL_W wide enough to address N");
        end
    endgenerate

    localparam logic [SEL_W:0] N_LIMIT = (SEL_W + 1)'(N);

    logic [N-1:0]          w_free;
    logic [N-1:0]          w_sel_hot;
    logic [N-1:0]          w_load;
    logic [WIDTH-1:0]      w_slot_data [N];
    sel_kind_e             w_kind;
    logic                  w_accept;
    logic                  w_drop;
    logic                  r_err;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    always_comb begin
        w_sel_hot = '0;
        for (int k = 0; k < N; k++) begin
            w_sel_hot[k] = (in_sel == SEL_W'(k));
        end
    end

    always_comb begin
        w_kind = KIND_DROP;
        if (in_bcast)                     w_kind = KIND_BCAST;
        else if ({1'b0, in_sel} < N_LIMIT) w_kind = KIND_UNICAST;
    end

    // A broadcast waits for every slot, so it can never land in only some channels.
    always_comb begin
        in_ready = 1'b0;
        unique case (w_kind)
            KIND_UNICAST: in_ready = |(w_sel_hot & w_free);
            KIND_BCAST:   in_ready = &w_free;
            KIND_DROP:    in_ready = 1'b1;
            default:      in_ready = 1'b0;
        endcase
        if (rst) in_ready = 1'b0;
    end

    assign w_accept = in_valid && in_ready;
    assign w_drop   = w_accept && (w_kind == KIND_DROP);

    always_comb begin
        w_load = '0;
        if (w_accept) begin
            if (w_kind == KIND_BCAST)        w_load = '1;
            else if (w_kind == KIND_UNICAST) w_load = w_sel_hot;
        end
    end

    generate
        for (genvar k = 0; k < N; k++) begin : g_slot
            demux_slot #(.WIDTH(WIDTH)) u_slot (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_load[k]),
                .i_data  (in_data),
                .i_ready (out_ready[k]),
                .o_valid (out_valid[k]),
                .o_data  (w_slot_data[k]),
                .o_free  (w_free[k])
            );
            assign out_data[k*WIDTH +: WIDTH] = w_slot_data[k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_err <= w_drop;
            if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign err      = r_err;
    assign drop_cnt = r_drop_cnt;

endmodule
